// File: rtl/eight_bit_restoring_divider.sv
// eight_bit_restoring_divider
//
// Sequential 8-bit unsigned divider using restoring shift-subtract. It
// retires one quotient bit per clock. Each trial subtraction is formed as
// shifted + ~D + 1 and is evaluated with generate/propagate look-ahead
// carries, which is the same arithmetic as the 8-bit look-ahead adder.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous, active-low reset
//   start        request; sampled only while idle
//   dividend     unsigned dividend, sampled together with start
//   divisor      unsigned divisor, sampled together with start
//   quotient     registered quotient of the last completed operation
//   remainder    registered remainder of the last completed operation
//   busy         high whenever the divider is not idle
//   done         one-cycle pulse; results are valid while it is high
//   div_by_zero  registered flag; set when the last operation had divisor 0

module eight_bit_restoring_divider (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [2:0] cnt;
  logic [7:0] d_reg;
  logic [7:0] q_reg;
  logic [7:0] r_reg;

  logic [8:0] shifted;
  logic [8:0] trial;
  logic       no_borrow;
  logic [7:0] r_next;
  logic [7:0] q_next;

  // 9-bit carry look-ahead adder. Each carry is the flattened sum-of-products
  // of generates and propagates, so no carry waits on its neighbour.
  // The result is returned as {carry_out, sum[8:0]}.
  function automatic logic [9:0] cla9(input logic [8:0] a,
                                      input logic [8:0] b,
                                      input logic       cin);
    logic [8:0] g;
    logic [8:0] p;
    logic [9:0] c;
    logic [8:0] s;
    logic       acc;
    logic       pp;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < 9; i++) begin
      acc = 1'b0;
      pp  = 1'b1;
      for (int j = i; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      c[i+1] = acc | (pp & cin);
    end
    s = p ^ c[8:0];
    return {c[9], s};
  endfunction

  // One restoring iteration. The partial remainder takes in the next
  // dividend bit. Then the divisor is trial-subtracted. A carry out of the
  // 9-bit add means the subtraction did not borrow, so the difference is
  // kept and the quotient bit is 1. Otherwise the shifted value is restored.
  always_comb begin
    logic [9:0] sum;
    shifted   = {r_reg, q_reg[7]};
    sum       = cla9(shifted, {1'b1, ~d_reg}, 1'b1);
    trial     = sum[8:0];
    no_borrow = sum[9];
    if (no_borrow) begin
      r_next = trial[7:0];
      q_next = {q_reg[6:0], 1'b1};
    end else begin
      r_next = shifted[7:0];
      q_next = {q_reg[6:0], 1'b0};
    end
  end

  // State register. Reset forces the FSM back to idle at any time and
  // abandons whatever operation is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the status outputs. A zero divisor skips the
  // iteration phase and goes straight to the result cycle.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (divisor == 8'd0) ? DONE : CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == 3'd7) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath and result registers. Operands are captured only on an
  // accepted start. The visible results change only when the FSM enters
  // DONE, so they stay stable between operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= 3'd0;
      d_reg       <= 8'd0;
      q_reg       <= 8'd0;
      r_reg       <= 8'd0;
      quotient    <= 8'd0;
      remainder   <= 8'd0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor != 8'd0) begin
              d_reg <= divisor;
              q_reg <= dividend;
              r_reg <= 8'd0;
              cnt   <= 3'd0;
            end else begin
              quotient    <= 8'hFF;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        CALC: begin
          r_reg <= r_next;
          q_reg <= q_next;
          cnt   <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            quotient    <= q_next;
            remainder   <= r_next;
            div_by_zero <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eight_bit_restoring_divider.sv
// Testbench for eight_bit_restoring_divider.
//
// Stimulus pushes the expected result into a scoreboard queue. A separate
// monitor pops that queue and compares it against the DUT outputs whenever
// done is high. A done pulse that arrives with no expectation queued is
// reported as a spurious done.

module tb_eight_bit_restoring_divider;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
  } exp_t;

  typedef struct packed {
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic [7:0] q;
    logic [7:0] r;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  exp_t sb[$];
  int   tests_run  = 0;
  int   tests_fail = 0;
  int   done_count = 0;

  eight_bit_restoring_divider dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  // 10 ns clock period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value against its expectation and update the counters.
  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: sample on the falling edge, and pop one expectation per done cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_count++;
        if (sb.size() == 0) begin
          checkOutput("spurious_done", 1, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("quotient", quotient, e.q);
          checkOutput("remainder", remainder, e.r);
          checkOutput("div_by_zero", div_by_zero, e.dbz);
        end
      end
    end
  end

  // Wait, within a bounded number of cycles, until the DUT is idle. The
  // caller returns just after a falling edge.
  task automatic waitIdle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy === 1'b1) checkOutput("idle_timeout", 1, 0);
  endtask

  // Issue one request and push its expected result. Then check the latency
  // from the accepting edge to done, that busy stays high throughout, and
  // that busy drops after the done cycle.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] eq, input logic [7:0] er);
    int cycles;
    int busy_cycles;
    exp_t e;
    waitIdle();
    e.q = eq; e.r = er; e.dbz = (b == 8'd0);
    sb.push_back(e);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dividend = 8'hXX;
    divisor  = 8'hXX;
    cycles = 0;
    busy_cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (busy === 1'b1) busy_cycles++;
    end while (done !== 1'b1 && cycles < 30);
    checkOutput("latency", cycles, (b == 8'd0) ? 1 : 9);
    checkOutput("busy_cycles", busy_cycles, (b == 8'd0) ? 1 : 9);
    @(negedge clk);
    checkOutput("busy_after_done", busy, 0);
  endtask

  vec_t vecs[] = '{
    '{8'd200, 8'd7,   8'd28,  8'd4},
    '{8'd255, 8'd1,   8'd255, 8'd0},
    '{8'd3,   8'd200, 8'd0,   8'd3},
    '{8'd0,   8'd5,   8'd0,   8'd0},
    '{8'd255, 8'd255, 8'd1,   8'd0},
    '{8'd5,   8'd0,   8'hFF,  8'd5},
    '{8'd10,  8'd3,   8'd3,   8'd1},
    '{8'd128, 8'd16,  8'd8,   8'd0},
    '{8'd254, 8'd13,  8'd19,  8'd7},
    '{8'd1,   8'd255, 8'd0,   8'd1},
    '{8'd0,   8'd0,   8'hFF,  8'd0},
    '{8'd99,  8'd10,  8'd9,   8'd9},
    '{8'd17,  8'd17,  8'd1,   8'd0}
  };

  initial begin
    int base;
    exp_t e;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    repeat (2) @(negedge clk);

    // Outputs while held in reset
    checkOutput("reset_quotient", quotient, 0);
    checkOutput("reset_remainder", remainder, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_dbz", div_by_zero, 0);
    rst_n = 1'b1;

    // Directed vectors, issued back-to-back as soon as the DUT is idle
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].dividend, vecs[i].divisor, vecs[i].q, vecs[i].r);
    end

    // Start held high with changing operands while busy: only the first
    // operands count, and there must be exactly one done pulse.
    waitIdle();
    base = done_count;
    e.q = 8'd28; e.r = 8'd4; e.dbz = 1'b0;
    sb.push_back(e);
    dividend = 8'd200;
    divisor  = 8'd7;
    start    = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      dividend = 8'(i * 37 + 11);
      divisor  = 8'(i + 2);
    end
    start = 1'b0;
    repeat (15) @(negedge clk);
    checkOutput("single_done_while_busy", done_count - base, 1);

    // Reset in the middle of an operation. The outputs must clear at once,
    // and no done pulse may follow.
    applyStimulus(8'd5, 8'd0, 8'hFF, 8'd5);
    waitIdle();
    dividend = 8'd77;
    divisor  = 8'd6;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    base = done_count;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_quotient", quotient, 0);
    checkOutput("async_rst_remainder", remainder, 0);
    checkOutput("async_rst_busy", busy, 0);
    checkOutput("async_rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("no_done_after_reset", done_count - base, 0);
    applyStimulus(8'd100, 8'd9, 8'd11, 8'd1);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
    $finish;
  end

  // Global bound so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got timeout, expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
